// File: rtl/jogo_sequencia_uc.sv
// jogo_sequencia_uc -- control unit (Moore FSM) for the sequence-memory game.
// Sequences one round: clear the datapath, wait for a player move, register
// it, compare it with the memory word, then advance or finish.
// Optional feature: define JOGO_SEQUENCIA_UC_TIMEOUT_EN to enable the move
// timeout. This adds the fim_timeout state, the espera timeout exit, the
// zeraT/contaT drive and the timeout flag. Without the macro, fimT is ignored.
module jogo_sequencia_uc (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       igual,
    input  logic       fimC,
    input  logic       fimT,
    output logic       zeraC,
    output logic       contaC,
    output logic       zeraR,
    output logic       registraR,
    output logic       zeraT,
    output logic       contaT,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    // State codes double as the debug code shown on db_estado
    localparam logic [3:0] INICIAL     = 4'h0;
    localparam logic [3:0] PREPARACAO  = 4'h1;
    localparam logic [3:0] ESPERA      = 4'h2;
    localparam logic [3:0] REGISTRA    = 4'h4;
    localparam logic [3:0] COMPARACAO  = 4'h5;
    localparam logic [3:0] PROXIMO     = 4'h6;
    localparam logic [3:0] FIM_ACERTO  = 4'hA;
    localparam logic [3:0] FIM_TIMEOUT = 4'hD;
    localparam logic [3:0] FIM_ERRO    = 4'hE;
    localparam logic [3:0] INVALIDO    = 4'hF;

    logic [3:0] estado_reg;
    logic [3:0] estado_next;

`ifndef JOGO_SEQUENCIA_UC_TIMEOUT_EN
    // With the timeout disabled fimT has no consumer; keep it visibly tied off
    logic unused_fimt;
    assign unused_fimt = fimT;
`endif

    // State register; reset returns to inicial without waiting for a clock edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_reg <= INICIAL;
        end else begin
            estado_reg <= estado_next;
        end
    end

    // Next-state logic; iniciar only matters in inicial and the final states
    always_comb begin
        estado_next = INICIAL;
        case (estado_reg)
            INICIAL:     estado_next = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:  estado_next = ESPERA;
            ESPERA: begin
                // A move always beats an expiring timer in the same cycle
                if (jogada) begin
                    estado_next = REGISTRA;
`ifdef JOGO_SEQUENCIA_UC_TIMEOUT_EN
                end else if (fimT) begin
                    estado_next = FIM_TIMEOUT;
`endif
                end else begin
                    estado_next = ESPERA;
                end
            end
            REGISTRA:    estado_next = COMPARACAO;
            COMPARACAO: begin
                if (!igual) begin
                    estado_next = FIM_ERRO;
                end else if (fimC) begin
                    estado_next = FIM_ACERTO;
                end else begin
                    estado_next = PROXIMO;
                end
            end
            PROXIMO:     estado_next = ESPERA;
            FIM_ACERTO:  estado_next = iniciar ? PREPARACAO : FIM_ACERTO;
            FIM_ERRO:    estado_next = iniciar ? PREPARACAO : FIM_ERRO;
`ifdef JOGO_SEQUENCIA_UC_TIMEOUT_EN
            FIM_TIMEOUT: estado_next = iniciar ? PREPARACAO : FIM_TIMEOUT;
`endif
            // Unused encodings recover to inicial on the next edge
            default:     estado_next = INICIAL;
        endcase
    end

    // Moore output decode: every output depends on the current state only
    always_comb begin
        zeraC     = 1'b0;
        contaC    = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
        zeraT     = 1'b0;
        contaT    = 1'b0;
        pronto    = 1'b0;
        acertou   = 1'b0;
        errou     = 1'b0;
        timeout   = 1'b0;
        db_estado = INVALIDO;
        case (estado_reg)
            INICIAL, PREPARACAO: begin
                zeraC     = 1'b1;
                zeraR     = 1'b1;
`ifdef JOGO_SEQUENCIA_UC_TIMEOUT_EN
                zeraT     = 1'b1;
`endif
                db_estado = estado_reg;
            end
            ESPERA: begin
`ifdef JOGO_SEQUENCIA_UC_TIMEOUT_EN
                contaT    = 1'b1;
`endif
                db_estado = estado_reg;
            end
            REGISTRA: begin
                registraR = 1'b1;
                db_estado = estado_reg;
            end
            COMPARACAO: begin
                db_estado = estado_reg;
            end
            PROXIMO: begin
                contaC    = 1'b1;
`ifdef JOGO_SEQUENCIA_UC_TIMEOUT_EN
                // Each new move gets a fresh timeout window
                zeraT     = 1'b1;
`endif
                db_estado = estado_reg;
            end
            FIM_ACERTO: begin
                pronto    = 1'b1;
                acertou   = 1'b1;
                db_estado = estado_reg;
            end
            FIM_ERRO: begin
                pronto    = 1'b1;
                errou     = 1'b1;
                db_estado = estado_reg;
            end
`ifdef JOGO_SEQUENCIA_UC_TIMEOUT_EN
            FIM_TIMEOUT: begin
                pronto    = 1'b1;
                timeout   = 1'b1;
                db_estado = estado_reg;
            end
`endif
            default: begin
                db_estado = INVALIDO;
            end
        endcase
    end

endmodule

// File: tb/tb_jogo_sequencia_uc.sv
// Self-checking bench for jogo_sequencia_uc. Every cycle the expected next
// state code is pushed to a scoreboard queue when the inputs are driven, and
// popped and compared (state code plus decoded outputs) at the following
// falling edge. Works with or without JOGO_SEQUENCIA_UC_TIMEOUT_EN.
module tb_jogo_sequencia_uc;

`ifdef JOGO_SEQUENCIA_UC_TIMEOUT_EN
    localparam bit TE = 1'b1;
`else
    localparam bit TE = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0;
    logic       jogada = 1'b0;
    logic       igual = 1'b0;
    logic       fimC = 1'b0;
    logic       fimT = 1'b0;
    logic       zeraC, contaC, zeraR, registraR, zeraT, contaT;
    logic       pronto, acertou, errou, timeout;
    logic [3:0] db_estado;

    int vectors = 0;
    int miscompares = 0;
    int contac_pulses = 0;
    logic [3:0] exp_q[$];

    jogo_sequencia_uc dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .jogada    (jogada),
        .igual     (igual),
        .fimC      (fimC),
        .fimT      (fimT),
        .zeraC     (zeraC),
        .contaC    (contaC),
        .zeraR     (zeraR),
        .registraR (registraR),
        .zeraT     (zeraT),
        .contaT    (contaT),
        .pronto    (pronto),
        .acertou   (acertou),
        .errou     (errou),
        .timeout   (timeout),
        .db_estado (db_estado)
    );

    always #5 clock = ~clock;

    // Watchdog so the run can never hang
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected outputs for a state code:
    // {zeraC,contaC,zeraR,registraR,zeraT,contaT,pronto,acertou,errou,timeout}
    function automatic logic [9:0] outs_for(input logic [3:0] st);
        case (st)
            4'h0, 4'h1: return {1'b1, 1'b0, 1'b1, 1'b0, TE,   1'b0, 4'b0000};
            4'h2:       return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, TE,   4'b0000};
            4'h4:       return {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000};
            4'h6:       return {1'b0, 1'b1, 1'b0, 1'b0, TE,   1'b0, 4'b0000};
            4'hA:       return {6'b000000, 4'b1100};
            4'hE:       return {6'b000000, 4'b1010};
            4'hD:       return {6'b000000, 4'b1001};
            default:    return 10'b0;
        endcase
    endfunction

    function automatic logic [9:0] outs_now();
        return {zeraC, contaC, zeraR, registraR, zeraT, contaT,
                pronto, acertou, errou, timeout};
    endfunction

    // Drive one cycle of inputs, queue the expected next state, then compare
    task automatic step(input logic ini, input logic jog, input logic ig,
                        input logic fc, input logic ft, input logic [3:0] exp_st);
        logic [3:0] e;
        iniciar = ini; jogada = jog; igual = ig; fimC = fc; fimT = ft;
        exp_q.push_back(exp_st);
        @(posedge clock);
        @(negedge clock);
        e = exp_q.pop_front();
        check_val("estado", {12'd0, db_estado}, {12'd0, e});
        check_val("saidas", {6'd0, outs_now()}, {6'd0, outs_for(e)});
        if (contaC) contac_pulses++;
        $display("step ini=%0b jog=%0b ig=%0b fimC=%0b fimT=%0b -> db_estado=%0h (exp %0h)",
                 ini, jog, ig, fc, ft, db_estado, e);
    endtask

    // One successful or failing move starting from espera
    task automatic move(input logic ig, input logic fc, input logic [3:0] final_st);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h4);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h5);
        step(1'b0, 1'b0, ig, fc, 1'b0, final_st);
        if (final_st == 4'h6) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2);
    endtask

    initial begin
        // Reset state
        @(negedge clock);
        reset = 1'b1;
        #2;
        check_val("reset_estado", {12'd0, db_estado}, 16'h0000);
        check_val("reset_saidas", {6'd0, outs_now()}, {6'd0, outs_for(4'h0)});
        @(negedge clock);
        reset = 1'b0;
        $display("reset applied -> db_estado=%0h", db_estado);

        // Idle in inicial, then a full winning round of four moves
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2);
        contac_pulses = 0;
        move(1'b1, 1'b0, 4'h6);
        move(1'b1, 1'b0, 4'h6);
        move(1'b1, 1'b0, 4'h6);
        move(1'b1, 1'b1, 4'hA);
        check_val("contaC_pulsos", 16'(contac_pulses), 16'd3);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hA);

        // Restart from fim_acerto, then lose on the second move
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2);
        move(1'b1, 1'b0, 4'h6);
        move(1'b0, 1'b0, 4'hE);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hE);

        // New round; iniciar is ignored mid-round, jogada beats fimT
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h4);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h5);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h6);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2);

        // Timer expiry in espera without a move
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, TE ? 4'hD : 4'h2);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, TE ? 4'hD : 4'h2);
        if (TE) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1);
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2);
        end

        // Asynchronous reset while in comparacao
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h4);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h5);
        #2;
        reset = 1'b1;
        #1;
        check_val("async_reset_estado", {12'd0, db_estado}, 16'h0000);
        check_val("async_reset_zera", {14'd0, zeraC, zeraR}, 16'h0003);
        $display("async reset in comparacao -> db_estado=%0h", db_estado);
        @(negedge clock);
        reset = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1);

        check_val("fila_vazia", 16'(exp_q.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
